// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, drives the instruction-memory address, selects the next PC
// (sequential / branch / jump) and owns the IF/ID pipeline register.
// A fetched HALT opcode parks the stage in HALT until a redirect arrives
// from downstream, which means the halt sat on a mispredicted path.
module instruction_fetch #(
  parameter int              B           = 32,
  parameter logic [B-1:0]    PC_RESET    = {B{1'b0}},
  parameter logic [5:0]      HALT_OPCODE = 6'b111111,
  parameter logic [B-1:0]    NOP         = {B{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [B-1:0] branch_target,
  input  logic         jump,
  input  logic [B-1:0] pc_jump,
  output logic [B-1:0] imem_addr,
  input  logic [B-1:0] imem_data,
  output logic [B-1:0] instruction,
  output logic [B-1:0] pc_incrementado,
  output logic         if_valid,
  output logic         halted,
  output logic [B-1:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [B-1:0] PC_STEP   = {{(B-3){1'b0}}, 3'b100};
  localparam logic [B-1:0] COUNT_ONE = {{(B-1){1'b0}}, 1'b1};
  localparam logic [B-1:0] ZERO_WORD = {B{1'b0}};

  state_t       state_r;
  logic [B-1:0] pc_r;
  logic [B-1:0] instr_r;
  logic [B-1:0] pc_inc_r;
  logic         valid_r;
  logic         halted_r;
  logic [B-1:0] count_r;

  logic         redir_s;
  logic [B-1:0] target_s;
  logic [B-1:0] pc_plus4_s;
  logic         halt_op_s;

  // Jump wins over branch when both redirect in the same cycle.
  assign redir_s    = jump | branch_taken;
  assign target_s   = jump ? pc_jump : branch_target;
  assign pc_plus4_s = pc_r + PC_STEP;
  assign halt_op_s  = (imem_data[B-1:B-6] == HALT_OPCODE);

  assign imem_addr       = pc_r;
  assign instruction     = instr_r;
  assign pc_incrementado = pc_inc_r;
  assign if_valid        = valid_r;
  assign halted          = halted_r;
  assign fetch_count     = count_r;

  // PC, run/halt FSM, IF/ID register and fetch counter, all frozen when enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_RUN;
      pc_r     <= PC_RESET;
      instr_r  <= NOP;
      pc_inc_r <= ZERO_WORD;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      count_r  <= ZERO_WORD;
    end else if (enable) begin
      case (state_r)
        ST_RUN: begin
          // Redirect beats stall and beats a freshly fetched HALT.
          if (redir_s) begin
            pc_r <= target_s;
          end else if (stall) begin
            pc_r <= pc_r;
          end else if (halt_op_s) begin
            pc_r     <= pc_r;
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            pc_r <= pc_plus4_s;
          end
          // IF/ID: flush > stall > load; the HALT word itself is loaded so it drains.
          if (flush) begin
            instr_r  <= NOP;
            pc_inc_r <= ZERO_WORD;
            valid_r  <= 1'b0;
          end else if (stall) begin
            instr_r  <= instr_r;
            pc_inc_r <= pc_inc_r;
            valid_r  <= valid_r;
          end else begin
            instr_r  <= imem_data;
            pc_inc_r <= pc_plus4_s;
            valid_r  <= 1'b1;
            count_r  <= count_r + COUNT_ONE;
          end
        end
        ST_HALT: begin
          // Only a redirect leaves HALT; a bare flush keeps us parked.
          if (redir_s) begin
            pc_r     <= target_s;
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else begin
            pc_r <= pc_r;
          end
          // While halted the stage only emits bubbles unless stalled.
          if (stall && !flush) begin
            instr_r  <= instr_r;
            pc_inc_r <= pc_inc_r;
            valid_r  <= valid_r;
          end else begin
            instr_r  <= NOP;
            pc_inc_r <= ZERO_WORD;
            valid_r  <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_RUN;
          halted_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
      pc_r    <= pc_r;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a cycle model pushes expected
// outputs into a scoreboard queue when stimulus is driven, and the queue is
// popped and compared just after the following rising edge.
module tb_instruction_fetch;

  localparam int B = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable, stall, flush, branch_taken, jump;
  logic [B-1:0] branch_target, pc_jump;
  logic [B-1:0] imem_addr, imem_data;
  logic [B-1:0] instruction, pc_incrementado, fetch_count;
  logic         if_valid, halted;

  instruction_fetch #(.B(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .pc_jump(pc_jump), .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .pc_incrementado(pc_incrementado),
    .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory image: a few fixed words, everything else a non-HALT addi.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2008_0005;
      32'h0000_0004: mem_word = 32'h2009_0003;
      32'h0000_0010: mem_word = 32'hFC00_0000;
      default:       mem_word = {6'h08, a[25:0]};
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcinc;
    logic [31:0] cnt;
    logic        valid;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pcinc, m_cnt;
  logic        m_valid, m_halt;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcinc = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pcinc = m_pcinc; e.cnt = m_cnt;
    e.valid = m_valid; e.halt = m_halt;
    sb.push_back(e);
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check_value({tag, ".pc"},    imem_addr,       e.pc);
      check_value({tag, ".instr"}, instruction,     e.instr);
      check_value({tag, ".pcinc"}, pc_incrementado, e.pcinc);
      check_value({tag, ".count"}, fetch_count,     e.cnt);
      check_value({tag, ".valid"}, {31'h0, if_valid}, {31'h0, e.valid});
      check_value({tag, ".halt"},  {31'h0, halted},   {31'h0, e.halt});
    end
  endtask

  // Next-state of the reference model for one enabled/disabled clock.
  task automatic model_step(input logic en, input logic st, input logic fl,
                            input logic br, input logic [31:0] bt,
                            input logic jp, input logic [31:0] pj);
    logic [31:0] word, tgt, npc, seq;
    logic        redir, nhalt;
    word  = mem_word(m_pc);
    redir = jp | br;
    tgt   = jp ? pj : bt;
    seq   = m_pc + 32'd4;
    npc   = m_pc;
    nhalt = m_halt;
    if (en) begin
      if (!m_halt) begin
        if (redir) npc = tgt;
        else if (!st && word[31:26] == 6'b111111) nhalt = 1'b1;
        else if (!st) npc = seq;
        if (fl) begin
          m_instr = 32'h0; m_pcinc = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
          m_instr = word; m_pcinc = seq; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
      end else begin
        if (redir) begin
          npc = tgt; nhalt = 1'b0;
        end
        if (fl || !st) begin
          m_instr = 32'h0; m_pcinc = 32'h0; m_valid = 1'b0;
        end
      end
      m_pc   = npc;
      m_halt = nhalt;
    end
  endtask

  task automatic step(input string tag, input logic en, input logic st, input logic fl,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] pj);
    @(negedge clk);
    enable = en; stall = st; flush = fl;
    branch_taken = br; branch_target = bt; jump = jp; pc_jump = pj;
    model_step(en, st, fl, br, bt, jp, pj);
    push_expected();
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    logic [31:0] r_bt, r_pj;
    reset = 1'b0;
    enable = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; pc_jump = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_expected();
    compare_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    step("fetch0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("fetch1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall2", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("unstall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("combo", 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40);
    step("fetch40", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("jump10", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
    step("halt_fetch", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("halt_idle1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("halt_idle2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("halt_stall", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("halt_flush", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("halt_exit", 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    step("fetch20", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("jump10b", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
    step("halt_vs_redir", 1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++)
      step("disabled", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h44);

    // Reset pulse entirely between clock edges.
    @(negedge clk);
    enable = 1'b0; jump = 1'b0; flush = 1'b0;
    #1 reset = 1'b0;
    #1;
    model_reset();
    push_expected();
    compare_outputs("midreset");
    #1 reset = 1'b1;

    step("refetch0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("jump_top", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r_bt = 32'($urandom_range(0, 31)) << 2;
      r_pj = 32'($urandom_range(0, 31)) << 2;
      step("random", ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), r_bt,
           ($urandom_range(0, 9) == 0), r_pj);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
